// File: rtl/window_fetch_if.sv
// window_fetch_if: single-word RAM read port plus the KxK window valid/ready output of window_fetch.
interface window_fetch_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 16,
  parameter int K      = 5,
  parameter int MAP_W  = 6
);
  logic                  mem_rd_en;
  logic [ADDR_W-1:0]     mem_addr;
  logic [DATA_W-1:0]     mem_rd_data;
  logic                  mem_rd_valid;
  logic [K*K*DATA_W-1:0] win_data;
  logic [MAP_W-1:0]      win_row;
  logic [MAP_W-1:0]      win_col;
  logic                  win_valid;
  logic                  win_ready;
  modport master (
    output mem_rd_en, mem_addr, win_data, win_row, win_col, win_valid,
    input  mem_rd_data, mem_rd_valid, win_ready
  );
  modport slave (
    input  mem_rd_en, mem_addr, win_data, win_row, win_col, win_valid,
    output mem_rd_data, mem_rd_valid, win_ready
  );
endinterface

// File: rtl/window_fetch.sv
// window_fetch: walks a square row-major map in RAM and assembles one KxK window at a time.
// Build option WINDOW_REUSE_EN: shift columns within a row and fetch only the new ones.
module window_fetch #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 16,
  parameter int K      = 5,
  parameter int MAP_W  = 6
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [MAP_W-1:0]  map_size,
  input  logic [2:0]        win_size,
  input  logic [1:0]        stride,
  window_fetch_if.master    bus,
  output logic              busy,
  output logic              done,
  output logic              err
);
  localparam int IW = $clog2(K*K);
  localparam int XW = MAP_W + 1;
  typedef enum logic [2:0] {IDLE, REQ, WAIT, PRESENT, FIN} state_t;
  state_t state, nxt;
  logic [ADDR_W-1:0] base_q, addr;
  logic [MAP_W-1:0]  n, y, x;
  logic [2:0]        w, r, c, c0;
  logic [1:0]        s;
  logic [DATA_W-1:0] win [K*K];
  logic [IW-1:0]     idx;
  logic              legal, last_el, last_x, last_y;
  assign legal   = win_size != 3'd0 && win_size <= 3'(K) && MAP_W'(win_size) <= map_size && stride != 2'd0;
  assign last_el = r == w - 3'd1 && c == w - 3'd1;
  assign last_x  = {1'b0, x} + XW'(s) + XW'(w) > {1'b0, n};
  assign last_y  = {1'b0, y} + XW'(s) + XW'(w) > {1'b0, n};
  assign idx     = IW'(r) * IW'(K) + IW'(c);
  assign addr    = base_q + (ADDR_W'(y) + ADDR_W'(r)) * ADDR_W'(n) + ADDR_W'(x) + ADDR_W'(c);
  assign bus.mem_addr = state == REQ ? addr : '0;
  assign bus.win_row  = y;
  assign bus.win_col  = x;
  for (genvar i = 0; i < K*K; i++) begin : g_out
    assign bus.win_data[i*DATA_W +: DATA_W] = win[i];
  end
`ifdef WINDOW_REUSE_EN
  logic [2:0]        cn;
  logic [DATA_W-1:0] sh [K*K];
  // First column still to fetch after a shift; a stride at least as wide as the window refetches all.
  assign cn = {1'b0, s} >= w ? 3'd0 : w - {1'b0, s};
  for (genvar i = 0; i < K; i++) begin : g_r
    for (genvar j = 0; j < K; j++) begin : g_c
      logic [DATA_W-1:0] a1, a2, a3;
      if (j + 1 < K) begin : g_1
        assign a1 = win[i*K+j+1];
      end else begin : g_1z
        assign a1 = '0;
      end
      if (j + 2 < K) begin : g_2
        assign a2 = win[i*K+j+2];
      end else begin : g_2z
        assign a2 = '0;
      end
      if (j + 3 < K) begin : g_3
        assign a3 = win[i*K+j+3];
      end else begin : g_3z
        assign a3 = '0;
      end
      assign sh[i*K+j] = s == 2'd1 ? a1 : s == 2'd2 ? a2 : a3;
    end
  end
`endif
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else state <= nxt;
  end
  always_comb begin
    nxt = state;
    bus.mem_rd_en = 1'b0;
    bus.win_valid = 1'b0;
    busy = 1'b0;
    done = 1'b0;
    case (state)
      IDLE: if (start) nxt = legal ? REQ : FIN;
      REQ: begin
        bus.mem_rd_en = 1'b1;
        busy = 1'b1;
        nxt = WAIT;
      end
      WAIT: begin
        busy = 1'b1;
        if (bus.mem_rd_valid) nxt = last_el ? PRESENT : REQ;
      end
      PRESENT: begin
        busy = 1'b1;
        bus.win_valid = 1'b1;
        if (bus.win_ready) nxt = last_x && last_y ? FIN : REQ;
      end
      FIN: begin
        done = 1'b1;
        nxt = IDLE;
      end
      default: nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      base_q <= '0;
      n <= '0;
      w <= '0;
      s <= '0;
      y <= '0;
      x <= '0;
      r <= '0;
      c <= '0;
      c0 <= '0;
      err <= 1'b0;
      for (int i = 0; i < K*K; i++) win[i] <= '0;
    end else begin
      if (state == IDLE && start) begin
        err <= !legal;
        if (legal) begin
          base_q <= base_addr;
          n <= map_size;
          w <= win_size;
          s <= stride;
          y <= '0;
          x <= '0;
          r <= '0;
          c <= '0;
          c0 <= '0;
          for (int i = 0; i < K*K; i++) win[i] <= '0;
        end
      end
      if (state == WAIT && bus.mem_rd_valid) begin
        win[idx] <= bus.mem_rd_data;
        if (c == w - 3'd1) begin
          c <= c0;
          r <= r + 3'd1;
        end else c <= c + 3'd1;
      end
      if (state == PRESENT && bus.win_ready && !(last_x && last_y)) begin
        r <= '0;
        if (last_x) begin
          x <= '0;
          y <= y + MAP_W'(s);
          c <= '0;
          c0 <= '0;
        end else begin
          x <= x + MAP_W'(s);
`ifdef WINDOW_REUSE_EN
          c <= cn;
          c0 <= cn;
          for (int i = 0; i < K*K; i++) win[i] <= sh[i];
`else
          c <= '0;
`endif
        end
      end
    end
  end
endmodule
